gate_sequencer: RTL and testbench
=================================

Name: gate_sequencer

Overview:
Sequences the physical barrier of the level crossing from per-track occupancy flags derived from the bogey counters. Drives warning lamps, siren and boom motor (down/up), checks motor limit switches with timeouts, and enforces a clearance hold before reopening. Sits between the occupancy logic and the gate actuators, and replaces the raw gate_open decision with a safety-sequenced one.

Parameters:
N_TRACKS, 2, number of occupancy inputs
WARN_CYC, 500, cycles of lamps+siren before boom starts lowering
MOTOR_TO_CYC, 2000, max cycles for a boom move before fault
CLEAR_CYC, 300, cycles all tracks must stay clear before raising
FLASH_CYC, 50, lamp half-period in cycles

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
occ  in  N_TRACKS  track occupied flags, synchronous to Clk (1 = train present)
limit_down  in  1  boom fully down switch, asynchronous
limit_up  in  1  boom fully up switch, asynchronous
fault_clr  in  1  single-cycle operator fault acknowledge
motor_down  out  1  drive boom downward
motor_up  out  1  drive boom upward
lamp  out  1  flashing warning lamp
siren  out  1  audible warning
gate_open  out  1  road open (asserted only in OPEN)
fault  out  1  sequencer in FAULT
state_dbg  out  3  current state encoding

Behaviour:
- Clock and reset: one clock, Clk; Reset is asynchronous and active-high. Reset forces state INIT, timer 0, flasher phase 0, and all outputs 0.
- limit_down and limit_up pass through 2-FF synchronisers, so FSM decisions lag those pins by 2 cycles. occ is used directly. any_occ = OR of occ.
- One down-counter timer. A load on a transition sets the timer to the state's constant. "Expires" means timer==0 while in the state. Outputs are registered from state, so they change one cycle after the state changes.
- States and transitions, evaluated in priority order:
  INIT(0): lim_up_s -> OPEN; otherwise -> RAISING, loading MOTOR_TO_CYC.
  OPEN(1): any_occ -> WARN, loading WARN_CYC.
  WARN(2): expires -> LOWERING, loading MOTOR_TO_CYC. Clearing of occ during WARN is ignored and the close completes.
  LOWERING(3): lim_down_s -> CLOSED. Expires -> FAULT.
  CLOSED(4): !any_occ -> HOLD, loading CLEAR_CYC.
  HOLD(5): any_occ -> CLOSED (clearance restarts on the next clear). Expires -> RAISING, loading MOTOR_TO_CYC.
  RAISING(6): any_occ -> LOWERING, reloading MOTOR_TO_CYC; this takes priority. lim_up_s -> OPEN. Expires -> FAULT.
  FAULT(7): motors off. fault_clr && !any_occ -> INIT. fault_clr is ignored otherwise.
- Global rule: lim_up_s && lim_down_s together in any state except FAULT -> FAULT on the next cycle.
- Output decode:
  motor_down = LOWERING.
  motor_up = RAISING or INIT-exit to RAISING.
  motor_down and motor_up are never both 1.
  siren = WARN, LOWERING or FAULT.
  Lamp enable = any state except OPEN and INIT. When enabled, lamp toggles every FLASH_CYC cycles, starting at 1 on enable. When disabled, lamp = 0 and the flasher resets.
  gate_open = OPEN. fault = FAULT.
- Reset mid-move: motors drop on the Reset edge; after release the FSM re-enters via INIT.

Decomposition:
- Shared package holds:
  - the state encoding constants (INIT..FAULT, 3 bits);
  - default timing constants;
  - a timer-width constant computed with $clog2 of the largest cycle parameter.
- One sub-module, lamp_flasher: enable in, FLASH_CYC parameter, square-wave lamp out, with its own counter.
- The synchronisers stay inline.

Test Plan:
- Use WARN_CYC=4, MOTOR_TO_CYC=10, CLEAR_CYC=3, FLASH_CYC=2.
- Reset release with limit_up=1 -> state INIT then OPEN; gate_open=1, all drives 0.
- occ=01, then limit_down asserted 5 cycles into LOWERING -> WARN for 4 cycles with siren=1, lamp toggling every 2 cycles; motor_down=1; CLOSED reached 2 cycles after the limit.
- Close, then occ 01->00 for 1 cycle ->01 -> HOLD then back to CLOSED. Then occ=00 for 3+ cycles -> RAISING, motor_up=1; limit_up -> OPEN, gate_open=1.
- Re-entry while RAISING: occ=10 -> next state LOWERING, motor_up=0 and motor_down=1, with no overlap cycle.
- LOWERING with limit_down never asserted -> FAULT after 10 cycles, fault=1, siren=1, motors 0. fault_clr with occ=10 -> stays FAULT. fault_clr with occ=00 -> INIT.
- limit_up and limit_down both held high in CLOSED -> FAULT 3 cycles later. Reset asserted mid-LOWERING -> motor_down=0 immediately (asynchronous).

Source files
------------

// File: rtl/gate_sequencer_pkg.sv
// Shared definitions for the level-crossing gate sequencer:
// state encoding, default timings and timer sizing helper.
package gate_sequencer_pkg;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        OPEN     = 3'd1,
        WARN     = 3'd2,
        LOWERING = 3'd3,
        CLOSED   = 3'd4,
        HOLD     = 3'd5,
        RAISING  = 3'd6,
        FAULT    = 3'd7
    } gs_state_e;

    localparam int N_TRACKS_DEF     = 2;
    localparam int WARN_CYC_DEF     = 500;
    localparam int MOTOR_TO_CYC_DEF = 2000;
    localparam int CLEAR_CYC_DEF    = 300;
    localparam int FLASH_CYC_DEF    = 50;

    function automatic int max_cyc(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    localparam int TIMER_W =
        $clog2(max_cyc(WARN_CYC_DEF, MOTOR_TO_CYC_DEF, CLEAR_CYC_DEF) + 1);

endpackage

// File: rtl/gate_sequencer_lamp_flasher.sv
// Square-wave warning lamp: toggles every FLASH_CYC cycles while enabled,
// first phase lit. Ports: Clk, Reset, enable in; lamp out.
module gate_sequencer_lamp_flasher #(
    parameter int FLASH_CYC = 50
) (
    input  logic Clk,
    input  logic Reset,
    input  logic enable,
    output logic lamp
);

    localparam int CW = (FLASH_CYC > 1) ? $clog2(FLASH_CYC) : 1;

    logic [CW-1:0] cnt;

    // Disabling clears the phase so the next enable starts lit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt  <= '0;
            lamp <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            lamp <= 1'b0;
        end else if (cnt == '0) begin
            lamp <= ~lamp;
            cnt  <= CW'(FLASH_CYC - 1);
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/gate_sequencer.sv
// Safety sequencer for a level-crossing boom: occupancy in, lamps/siren/motors out.
// Ports: Clk, Reset, occ, limit_down, limit_up, fault_clr in; motor_down, motor_up, lamp, siren, gate_open, fault, state_dbg out.
module gate_sequencer
    import gate_sequencer_pkg::*;
#(
    parameter int N_TRACKS     = N_TRACKS_DEF,
    parameter int WARN_CYC     = WARN_CYC_DEF,
    parameter int MOTOR_TO_CYC = MOTOR_TO_CYC_DEF,
    parameter int CLEAR_CYC    = CLEAR_CYC_DEF,
    parameter int FLASH_CYC    = FLASH_CYC_DEF
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [N_TRACKS-1:0] occ,
    input  logic                limit_down,
    input  logic                limit_up,
    input  logic                fault_clr,
    output logic                motor_down,
    output logic                motor_up,
    output logic                lamp,
    output logic                siren,
    output logic                gate_open,
    output logic                fault,
    output logic [2:0]          state_dbg
);

    localparam int TW =
        $clog2(max_cyc(WARN_CYC, MOTOR_TO_CYC, CLEAR_CYC) + 1);

    // Loaded with N-1 so a timed state lasts exactly N cycles.
    localparam logic [TW-1:0] T_WARN  = TW'(WARN_CYC - 1);
    localparam logic [TW-1:0] T_MOTOR = TW'(MOTOR_TO_CYC - 1);
    localparam logic [TW-1:0] T_CLEAR = TW'(CLEAR_CYC - 1);

    gs_state_e     state, state_nx;
    logic [TW-1:0] timer, tval;
    logic          tload;
    logic          up_meta, up_s, dn_meta, dn_s;
    logic          any_occ, expired, lamp_en;

    // Not reset: the chain keeps sampling through reset, so the switch
    // levels are already valid when INIT makes its first decision.
    always_ff @(posedge Clk) begin
        up_meta <= limit_up;
        up_s    <= up_meta;
        dn_meta <= limit_down;
        dn_s    <= dn_meta;
    end

    assign any_occ = |occ;
    assign expired = (timer == '0);

    always_comb begin
        state_nx = state;
        tload    = 1'b0;
        tval     = '0;
        if (up_s && dn_s && state != FAULT) begin
            state_nx = FAULT;
        end else begin
            unique case (state)
                INIT: begin
                    if (up_s) begin
                        state_nx = OPEN;
                    end else begin
                        state_nx = RAISING;
                        tload    = 1'b1;
                        tval     = T_MOTOR;
                    end
                end
                OPEN: begin
                    if (any_occ) begin
                        state_nx = WARN;
                        tload    = 1'b1;
                        tval     = T_WARN;
                    end
                end
                WARN: begin
                    if (expired) begin
                        state_nx = LOWERING;
                        tload    = 1'b1;
                        tval     = T_MOTOR;
                    end
                end
                LOWERING: begin
                    if (dn_s)         state_nx = CLOSED;
                    else if (expired) state_nx = FAULT;
                end
                CLOSED: begin
                    if (!any_occ) begin
                        state_nx = HOLD;
                        tload    = 1'b1;
                        tval     = T_CLEAR;
                    end
                end
                HOLD: begin
                    if (any_occ) begin
                        state_nx = CLOSED;
                    end else if (expired) begin
                        state_nx = RAISING;
                        tload    = 1'b1;
                        tval     = T_MOTOR;
                    end
                end
                RAISING: begin
                    // A train arriving mid-raise always wins.
                    if (any_occ) begin
                        state_nx = LOWERING;
                        tload    = 1'b1;
                        tval     = T_MOTOR;
                    end else if (up_s) begin
                        state_nx = OPEN;
                    end else if (expired) begin
                        state_nx = FAULT;
                    end
                end
                FAULT: begin
                    if (fault_clr && !any_occ) state_nx = INIT;
                end
                default: state_nx = FAULT;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= INIT;
            timer <= '0;
        end else begin
            state <= state_nx;
            if (tload)        timer <= tval;
            else if (!expired) timer <= timer - 1'b1;
        end
    end

    // Drives follow the state one cycle late; motor_up also leads by one
    // cycle out of INIT so the raise starts as RAISING is entered.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            motor_down <= 1'b0;
            motor_up   <= 1'b0;
            siren      <= 1'b0;
            gate_open  <= 1'b0;
            fault      <= 1'b0;
        end else begin
            motor_down <= (state == LOWERING);
            motor_up   <= (state == RAISING) ||
                          (state == INIT && state_nx == RAISING);
            siren      <= (state == WARN) || (state == LOWERING) ||
                          (state == FAULT);
            gate_open  <= (state == OPEN);
            fault      <= (state == FAULT);
        end
    end

    assign lamp_en = !(state == OPEN || state == INIT);

    gate_sequencer_lamp_flasher #(
        .FLASH_CYC (FLASH_CYC)
    ) u_flasher (
        .Clk    (Clk),
        .Reset  (Reset),
        .enable (lamp_en),
        .lamp   (lamp)
    );

    assign state_dbg = state;

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer: expected state transitions and outputs
// are queued by the stimulus and checked by an independent monitor.
module tb_gate_sequencer;
    import gate_sequencer_pkg::*;

    logic       clk, rst;
    logic [1:0] occ;
    logic       limit_down, limit_up, fault_clr;
    logic       motor_down, motor_up, lamp, siren, gate_open, fault;
    logic [2:0] state_dbg;

    typedef struct {
        logic [2:0] st;
        int         dw;
        logic [5:0] o;
        logic [5:0] m;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    bit   mon_en = 0;

    gate_sequencer #(
        .N_TRACKS     (2),
        .WARN_CYC     (4),
        .MOTOR_TO_CYC (10),
        .CLEAR_CYC    (3),
        .FLASH_CYC    (2)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .occ        (occ),
        .limit_down (limit_down),
        .limit_up   (limit_up),
        .fault_clr  (fault_clr),
        .motor_down (motor_down),
        .motor_up   (motor_up),
        .lamp       (lamp),
        .siren      (siren),
        .gate_open  (gate_open),
        .fault      (fault),
        .state_dbg  (state_dbg)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] outs();
        return {motor_down, motor_up, lamp, siren, gate_open, fault};
    endfunction

    // dw: cycles expected in the previous state (-1 = any); lp -1 = any.
    task automatic expect_st(input logic [2:0] st, input int dw,
                             input logic md, input logic mu, input int lp,
                             input logic sr, input logic go, input logic f);
        exp_t e;
        logic lb;
        lb   = (lp == 1);
        e.st = st;
        e.dw = dw;
        e.o  = {md, mu, lb, sr, go, f};
        e.m  = {1'b1, 1'b1, (lp >= 0), 1'b1, 1'b1, 1'b1};
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (state_dbg != s && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        nvec++;
        if (state_dbg != s) begin
            nerr++;
            $display("FAIL wait_state: state %0d, waited for %0d", state_dbg, s);
        end
    endtask

    // Monitor: a state change is the DUT presenting a result.
    initial begin
        logic [2:0] prev;
        int         cnt;
        bit         pend;
        exp_t       e, pe;
        logic [5:0] act;
        prev = '0;
        cnt  = 0;
        pend = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev = state_dbg;
                cnt  = 0;
                pend = 0;
            end else begin
                nvec++;
                if (motor_down && motor_up) begin
                    nerr++;
                    $display("FAIL motor_overlap: both motors on in state %0d", state_dbg);
                end
                if (pend) begin
                    act = outs();
                    nvec++;
                    if (((act ^ pe.o) & pe.m) != '0) begin
                        nerr++;
                        $display("FAIL outputs st=%0d: got %b, expected %b (mask %b)",
                                 pe.st, act, pe.o, pe.m);
                    end
                    pend = 0;
                end
                if (state_dbg != prev) begin
                    nvec++;
                    if (sb.size() == 0) begin
                        nerr++;
                        $display("FAIL unexpected_transition: %0d -> %0d", prev, state_dbg);
                    end else begin
                        e = sb.pop_front();
                        if (state_dbg != e.st || (e.dw >= 0 && cnt != e.dw)) begin
                            nerr++;
                            $display("FAIL transition: got state %0d after %0d cycles, expected %0d after %0d",
                                     state_dbg, cnt, e.st, e.dw);
                        end
                        pe   = e;
                        pend = 1;
                    end
                    prev = state_dbg;
                    cnt  = 1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] pat;
        pat = 5'b00110;
        rst = 1; occ = 0; limit_down = 0; limit_up = 1; fault_clr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", int'(state_dbg), 0);
        chk("reset_outs", int'(outs()), 0);
        @(posedge clk); #1;
        expect_st(OPEN, -1, 0, 0, 0, 0, 1, 0);
        rst = 0;
        mon_en = 1;
        wait_state(OPEN, 10);

        // Train on track 0: warn, lower, close.
        expect_st(WARN, -1, 0, 0, 1, 1, 0, 0);
        expect_st(LOWERING, 4, 1, 0, 1, 1, 0, 0);
        expect_st(CLOSED, 7, 0, 0, 0, 0, 0, 0);
        occ = 2'b01;
        limit_up = 0;
        wait_state(WARN, 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lamp_flash", int'(lamp), int'(pat[i]));
        end
        wait_state(LOWERING, 10);
        repeat (4) @(posedge clk);
        #1;
        limit_down = 1;
        wait_state(CLOSED, 10);

        // Brief clear restarts clearance, then a full clear raises.
        expect_st(HOLD, -1, 0, 0, -1, 0, 0, 0);
        expect_st(CLOSED, 1, 0, 0, -1, 0, 0, 0);
        occ = 0;
        @(posedge clk); #1;
        occ = 2'b01;
        @(posedge clk); #1;
        expect_st(HOLD, -1, 0, 0, -1, 0, 0, 0);
        expect_st(RAISING, 3, 0, 1, -1, 0, 0, 0);
        expect_st(OPEN, 5, 0, 0, 0, 0, 1, 0);
        occ = 0;
        wait_state(RAISING, 20);
        limit_down = 0;
        repeat (2) @(posedge clk);
        #1;
        limit_up = 1;
        wait_state(OPEN, 20);

        // Boom never reaches bottom: motor timeout fault.
        expect_st(WARN, -1, 0, 0, 1, 1, 0, 0);
        expect_st(LOWERING, 4, 1, 0, -1, 1, 0, 0);
        expect_st(FAULT, 10, 0, 0, -1, 1, 0, 1);
        occ = 2'b10;
        limit_up = 0;
        wait_state(FAULT, 40);
        fault_clr = 1;
        @(posedge clk); #1;
        fault_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("fault_held_while_occ", int'(state_dbg), int'(FAULT));
        expect_st(INIT, -1, 0, 1, 0, 0, 0, 0);
        expect_st(RAISING, 1, 0, 1, 1, 0, 0, 0);
        occ = 0;
        fault_clr = 1;
        @(posedge clk); #1;
        fault_clr = 0;

        // Train during raise: straight back to lowering.
        wait_state(RAISING, 10);
        expect_st(LOWERING, 1, 1, 0, -1, 1, 0, 0);
        occ = 2'b10;
        wait_state(LOWERING, 10);
        expect_st(CLOSED, 3, 0, 0, -1, 0, 0, 0);
        limit_down = 1;
        wait_state(CLOSED, 10);

        // Both limit switches at once: fault.
        expect_st(FAULT, 3, 0, 0, -1, 1, 0, 1);
        limit_up = 1;
        wait_state(FAULT, 10);
        limit_up = 0;
        limit_down = 0;
        occ = 0;
        repeat (3) @(posedge clk);
        #1;
        expect_st(INIT, -1, 0, 1, 0, 0, 0, 0);
        expect_st(RAISING, 1, 0, 1, 1, 0, 0, 0);
        fault_clr = 1;
        @(posedge clk); #1;
        fault_clr = 0;
        wait_state(RAISING, 10);
        expect_st(LOWERING, 1, 1, 0, -1, 1, 0, 0);
        occ = 2'b01;
        wait_state(LOWERING, 10);
        @(posedge clk); #1;
        chk("motor_down_before_reset", int'(motor_down), 1);

        // Reset mid-move drops the motor without a clock edge.
        @(negedge clk); #1;
        mon_en = 0;
        rst = 1;
        #1;
        chk("motor_down_async_drop", int'(motor_down), 0);
        chk("reset_mid_state", int'(state_dbg), 0);
        chk("reset_mid_outs", int'(outs()), 0);
        chk("sb_drained", sb.size(), 0);
        limit_up = 1;
        occ = 0;
        repeat (3) @(posedge clk);
        #1;
        expect_st(OPEN, -1, 0, 0, 0, 0, 1, 0);
        rst = 0;
        mon_en = 1;
        wait_state(OPEN, 10);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_final", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
